// File: rtl/add_responder_if.sv
// add_responder_if
//   Operand/result handshake bundle for add_responder.
//   Producer side : in_valid, a, b  ->  in_ready
//   Consumer side : out_ready       ->  out_valid, sum
//   Status        : count (FIFO occupancy), txn_count (accepted pairs mod 256)
//   master modport: the environment driving operands and draining results.
//   slave  modport: the responder itself.
interface add_responder_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         a;
  logic [WIDTH-1:0]         b;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH:0]           sum;
  logic [$clog2(DEPTH):0]   count;
  logic [7:0]               txn_count;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, count, txn_count
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, count, txn_count
  );
endinterface

// File: rtl/add_responder.sv
// add_responder
//   Accepts operand pairs over a valid/ready handshake, computes the
//   zero-extended sum a+b and buffers it in a DEPTH-entry FIFO that the
//   consumer drains over a second valid/ready handshake.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-high reset
//     bus  - add_responder_if.slave (operands, results, occupancy, txn count)
//   Parameters: WIDTH (operand width), DEPTH (FIFO entries, power of two >= 2)
module add_responder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  add_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     txn_q, txn_d;
  logic [WIDTH:0] mem_q [DEPTH];

  logic full, empty, push, pop;

  // Flags come from registered occupancy only, so in_ready has no
  // combinational dependence on out_ready.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = bus.out_ready && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    txn_d    = txn_q;
    // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      txn_d    = txn_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      txn_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      txn_q    <= txn_d;
    end
  end

  // Storage is deliberately not reset; stale entries are unreachable once
  // the pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {1'b0, bus.a} + {1'b0, bus.b};
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.sum       = mem_q[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.txn_count = txn_q;
endmodule
